// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with direct (binary select) and self-timed scan modes.
// Define ONEHOT_SCAN_ACTIVE_LOW_EN to make y one-cold (all-off = all ones).
module onehot_scan_decoder #(
    parameter int SEL_W    = 3,
    parameter int N_OUT    = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] y,
    output logic [SEL_W-1:0] idx,
    output logic             step,
    output logic             err
);

    localparam int              PS_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_OUT - 1);

`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
    localparam logic [N_OUT-1:0] Y_INV = {N_OUT{1'b1}};
`else
    localparam logic [N_OUT-1:0] Y_INV = {N_OUT{1'b0}};
`endif

    function automatic logic [N_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot = {{(N_OUT-1){1'b0}}, 1'b1} << i;
    endfunction

    logic [N_OUT-1:0] r_y;
    logic [SEL_W-1:0] r_idx;
    logic             r_step;
    logic             r_err;
    logic [PS_W-1:0]  r_ps;
    logic             r_mode;

    logic [N_OUT-1:0] w_y_n;
    logic [SEL_W-1:0] w_idx_n;
    logic             w_step_n;
    logic             w_err_n;
    logic [PS_W-1:0]  w_ps_n;
    logic             w_mode_chg;
    logic             w_sel_legal;
    logic [SEL_W-1:0] w_idx_wrap;

    assign w_mode_chg  = (mode != r_mode);
    assign w_sel_legal = ({{(32-SEL_W){1'b0}}, sel} < 32'(N_OUT));
    // Wrap at N_OUT rather than at the natural 2**SEL_W rollover.
    assign w_idx_wrap  = (r_idx == IDX_LAST) ? {SEL_W{1'b0}} : (r_idx + SEL_W'(1));

    // Next-state and next-output decode; y is computed active-high here.
    always_comb begin
        w_y_n    = {N_OUT{1'b0}};
        w_idx_n  = r_idx;
        w_step_n = 1'b0;
        w_err_n  = 1'b0;
        w_ps_n   = r_ps;
        if (!en) begin
            if (w_mode_chg) begin
                w_ps_n = {PS_W{1'b0}};
            end else begin
                w_ps_n = r_ps;
            end
        end else if (!mode) begin
            w_ps_n = {PS_W{1'b0}};
            if (w_sel_legal) begin
                w_y_n   = onehot(sel);
                w_idx_n = sel;
            end else begin
                w_err_n = 1'b1;
            end
        end else if (w_mode_chg) begin
            // Entering scan: restart the prescaler so the first step is a full period away.
            w_ps_n = {PS_W{1'b0}};
            w_y_n  = onehot(r_idx);
        end else if (r_ps == PS_LAST) begin
            w_ps_n   = {PS_W{1'b0}};
            w_step_n = 1'b1;
            w_idx_n  = w_idx_wrap;
            w_y_n    = onehot(w_idx_wrap);
        end else begin
            w_ps_n = r_ps + PS_W'(1);
            w_y_n  = onehot(r_idx);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y    <= Y_INV;
            r_idx  <= {SEL_W{1'b0}};
            r_step <= 1'b0;
            r_err  <= 1'b0;
            r_ps   <= {PS_W{1'b0}};
            r_mode <= 1'b0;
        end else begin
            r_y    <= w_y_n ^ Y_INV;
            r_idx  <= w_idx_n;
            r_step <= w_step_n;
            r_err  <= w_err_n;
            r_ps   <= w_ps_n;
            r_mode <= mode;
        end
    end

    assign y    = r_y;
    assign idx  = r_idx;
    assign step = r_step;
    assign err  = r_err;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench for onehot_scan_decoder (N_OUT=6, SEL_W=3, SCAN_DIV=4).
module tb_onehot_scan_decoder;

    localparam int SEL_W    = 3;
    localparam int N_OUT    = 6;
    localparam int SCAN_DIV = 4;

`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
    localparam logic [N_OUT-1:0] INV = {N_OUT{1'b1}};
`else
    localparam logic [N_OUT-1:0] INV = {N_OUT{1'b0}};
`endif

    typedef struct packed {
        logic [N_OUT-1:0] y;
        logic [SEL_W-1:0] idx;
        logic             step;
        logic             err;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [N_OUT-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             step;
    logic             err;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: current line, cycles spent on it in scan, last seen mode.
    int   m_idx;
    int   m_cnt;
    logic m_mode;

    onehot_scan_decoder #(.SEL_W(SEL_W), .N_OUT(N_OUT), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .y(y), .idx(idx), .step(step), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [N_OUT-1:0] line_on(input int i);
        logic [N_OUT-1:0] t;
        t    = {N_OUT{1'b0}};
        t[i] = 1'b1;
        return t;
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_cnt  = 0;
        m_mode = 1'b0;
    endtask

    // Apply one cycle of inputs and predict the outputs after the next rising edge.
    task automatic model_push(input logic e, input logic m, input int s);
        exp_t x;
        logic chg;
        chg    = (m != m_mode);
        m_mode = m;
        x.step = 1'b0;
        x.err  = 1'b0;
        x.y    = {N_OUT{1'b0}};
        if (!e) begin
            if (chg) m_cnt = 0;
        end else if (!m) begin
            m_cnt = 0;
            if (s < N_OUT) begin
                m_idx = s;
                x.y   = line_on(s);
            end else begin
                x.err = 1'b1;
            end
        end else if (chg) begin
            m_cnt = 0;
            x.y   = line_on(m_idx);
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == SCAN_DIV) begin
                m_cnt  = 0;
                m_idx  = (m_idx + 1) % N_OUT;
                x.step = 1'b1;
            end
            x.y = line_on(m_idx);
        end
        x.y   = x.y ^ INV;
        x.idx = SEL_W'(m_idx);
        q.push_back(x);
    endtask

    task automatic cyc(input logic e, input logic m, input int s);
        @(negedge clk);
        en   = e;
        mode = m;
        sel  = SEL_W'(s);
        model_push(e, m, s);
    endtask

    task automatic check_reset_vals();
        check("rst_y", 32'(y), 32'(INV));
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_reset_vals();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = '0;
        model_push(1'b0, 1'b0, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("y", 32'(y), 32'(e.y));
                check("idx", 32'(idx), 32'(e.idx));
                check("step", 32'(step), 32'(e.step));
                check("err", 32'(err), 32'(e.err));
            end
        end
    end

    initial begin
        logic rm;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        sel   = '0;
        model_reset();
        #1;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_push(1'b0, 1'b0, 0);

        // Direct sweep over every select value, including the illegal 6 and 7.
        for (int s = 0; s < 8; s++) cyc(1'b1, 1'b0, s);
        cyc(1'b1, 1'b0, 6);
        cyc(1'b1, 1'b0, 2);
        cyc(1'b1, 1'b0, 5);

        // Scan from idx 5 through two full wraps.
        for (int i = 0; i < 2 * N_OUT * SCAN_DIV + 2; i++) cyc(1'b1, 1'b1, 0);

        // Enable dropped for three cycles part-way through a step.
        cyc(1'b1, 1'b1, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 0);
        for (int i = 0; i < 2 * SCAN_DIV; i++) cyc(1'b1, 1'b1, 0);

        // Reset in mid-scan, then scan restarts from line 0.
        mid_reset();
        for (int i = 0; i < N_OUT * SCAN_DIV + 1; i++) cyc(1'b1, 1'b1, 0);

        // Randomised mix of modes, enables and selects.
        rm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) rm = ~rm;
            cyc(($urandom_range(0, 5) != 0), rm, int'($urandom_range(0, 7)));
        end

        cyc(1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #3;
        check("drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
